// File: rtl/padattr_pkg.sv
// -----------------------------------------------------------------------------
// padattr_pkg
// Shared types and helpers for the pad attribute sequencer.
//   - state_e    : sequencer FSM states (IDLE, APPLY, WAIT)
//   - NPads      : total pad count for the default padring configuration
//   - pad_loc_t  : decoded pad location (MIO/DIO plus local index)
//   - pad_split  : flat pad index -> (is_dio, local index)
// -----------------------------------------------------------------------------
package padattr_pkg;

    localparam int NMioPadsDef = 16;
    localparam int NDioPadsDef = 4;
    localparam int NPads       = NMioPadsDef + NDioPadsDef;

    // Wide enough for any realistic local pad index.
    localparam int LocIdxW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic               is_dio;
        logic [LocIdxW-1:0] local_idx;
    } pad_loc_t;

    // Flat indices 0..n_mio-1 are MIO pads; everything above is DIO,
    // renumbered from zero.
    function automatic pad_loc_t pad_split(input int unsigned flat_idx,
                                           input int unsigned n_mio);
        pad_loc_t loc;
        if (flat_idx < n_mio) begin
            loc.is_dio    = 1'b0;
            loc.local_idx = LocIdxW'(flat_idx);
        end else begin
            loc.is_dio    = 1'b1;
            loc.local_idx = LocIdxW'(flat_idx - n_mio);
        end
        return loc;
    endfunction

endpackage

// File: rtl/padattr_pick.sv
// -----------------------------------------------------------------------------
// padattr_pick
// Combinational lowest-set-bit priority encoder.
// Ports:
//   req_vec    in  N  request bitmap
//   pick_idx   out W  index of the lowest set bit (0 when none set)
//   pick_valid out 1  at least one bit of req_vec is set
// -----------------------------------------------------------------------------
module padattr_pick #(
    parameter int N = 20,
    parameter int W = 5
) (
    input  logic [N-1:0] req_vec,
    output logic [W-1:0] pick_idx,
    output logic         pick_valid
);

    // Scan upward; the first hit wins so lower indices take priority.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_vec[i] && !pick_valid) begin
                pick_idx   = W'(i);
                pick_valid = 1'b1;
            end else begin
                // an earlier (lower) index already won
            end
        end
    end

endmodule

// File: rtl/padattr_sequencer.sv
// -----------------------------------------------------------------------------
// padattr_sequencer
// Holds the live per-pad attributes driven into the padring. Writes land in a
// shadow copy and mark the pad pending; pending pads are then copied to the
// live array one at a time, lowest index first, with at least StaggerCycles
// cycles between applies so pad drive changes are spread out in time.
// Ports:
//   clk_i        in  1                 clock
//   rst_i        in  1                 synchronous reset, active high
//   req_valid_i  in  1                 attribute write request
//   req_ready_o  out 1                 write accepted when valid && ready
//   req_idx_i    in  IdxW              flat pad index (MIO first, then DIO)
//   req_attr_i   in  AttrDw            new attribute value
//   freeze_i     in  1                 holds off starting new applies
//   busy_o       out 1                 pending work or apply/stagger active
//   err_o        out 1                 pulse after an out-of-range write
//   mio_attr_o   out NMioPads*AttrDw   live MIO attributes, pad k at k*AttrDw
//   dio_attr_o   out NDioPads*AttrDw   live DIO attributes, same packing
// -----------------------------------------------------------------------------
module padattr_sequencer
    import padattr_pkg::*;
#(
    parameter int NMioPads      = 16,
    parameter int NDioPads      = 4,
    parameter int AttrDw        = 8,
    parameter int StaggerCycles = 4,
    parameter int IdxW          = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [IdxW-1:0]              req_idx_i,
    input  logic [AttrDw-1:0]            req_attr_i,
    input  logic                         freeze_i,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [NMioPads*AttrDw-1:0]   mio_attr_o,
    output logic [NDioPads*AttrDw-1:0]   dio_attr_o
);

    localparam int NumPads = NMioPads + NDioPads;

    // WAIT counts StaggerCycles-2 down to 0, which fits in clog2(StaggerCycles).
    localparam int CntW = (StaggerCycles > 2) ? $clog2(StaggerCycles) : 1;
    localparam logic [CntW-1:0] CntLoad =
        (StaggerCycles > 1) ? CntW'(StaggerCycles - 2) : '0;

    // One extra bit so the range check still works when NumPads == 2**IdxW.
    localparam logic [IdxW:0] NumPadsExt = (IdxW + 1)'(NumPads);

    state_e                          state_r;
    state_e                          state_n_s;
    logic [CntW-1:0]                 cnt_r;
    logic [CntW-1:0]                 cnt_n_s;
    logic [IdxW-1:0]                 sel_r;
    logic [IdxW-1:0]                 sel_n_s;
    logic                            apply_s;

    logic [NumPads-1:0][AttrDw-1:0]  shadow_r;
    logic [NumPads-1:0][AttrDw-1:0]  live_r;
    logic [NumPads-1:0]              pending_r;
    logic [NumPads-1:0]              wr_vec_s;
    logic [NumPads-1:0]              clr_vec_s;

    logic                            ready_r;
    logic                            busy_r;
    logic                            err_r;

    logic                            accept_s;
    logic                            in_range_s;
    logic [IdxW-1:0]                 pick_idx_s;
    logic                            pick_valid_s;

    assign accept_s = req_valid_i && ready_r;

    padattr_pick #(
        .N (NumPads),
        .W (IdxW)
    ) u_pick (
        .req_vec    (pending_r),
        .pick_idx   (pick_idx_s),
        .pick_valid (pick_valid_s)
    );

    // Decode the incoming write and the current apply into per-pad strobes.
    always_comb begin
        in_range_s = ({1'b0, req_idx_i} < NumPadsExt);
        wr_vec_s   = '0;
        clr_vec_s  = '0;
        for (int i = 0; i < NumPads; i++) begin
            if (accept_s && in_range_s && (req_idx_i == IdxW'(i))) begin
                wr_vec_s[i] = 1'b1;
            end else begin
                wr_vec_s[i] = 1'b0;
            end
            if (apply_s && (sel_r == IdxW'(i))) begin
                clr_vec_s[i] = 1'b1;
            end else begin
                clr_vec_s[i] = 1'b0;
            end
        end
    end

    // FSM state, stagger counter and selected pad registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sel_r   <= '0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            sel_r   <= sel_n_s;
        end
    end

    // FSM next-state logic; freeze only gates leaving IDLE, never an
    // apply/stagger already under way.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        sel_n_s   = sel_r;
        apply_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s && !freeze_i) begin
                    sel_n_s   = pick_idx_s;
                    state_n_s = APPLY;
                end else begin
                    state_n_s = IDLE;
                end
            end
            APPLY: begin
                apply_s = 1'b1;
                if (StaggerCycles == 1) begin
                    state_n_s = IDLE;
                end else begin
                    cnt_n_s   = CntLoad;
                    state_n_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == '0) begin
                    state_n_s = IDLE;
                end else begin
                    cnt_n_s = cnt_r - CntW'(1);
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Shadow, pending and live arrays. A write landing on the pad being
    // applied wins over the pending clear, so the new value gets its own pass
    // while live takes the shadow value from before this cycle's write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_r  <= '0;
            live_r    <= '0;
            pending_r <= '0;
        end else begin
            for (int i = 0; i < NumPads; i++) begin
                if (wr_vec_s[i]) begin
                    shadow_r[i] <= req_attr_i;
                end
                if (clr_vec_s[i]) begin
                    live_r[i] <= shadow_r[i];
                end
            end
            pending_r <= (pending_r & ~clr_vec_s) | wr_vec_s;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            busy_r  <= (|pending_r) || (state_r != IDLE);
            err_r   <= accept_s && !in_range_s;
        end
    end

    assign req_ready_o = ready_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;
    assign mio_attr_o  = live_r[NMioPads-1:0];
    assign dio_attr_o  = live_r[NumPads-1:NMioPads];

endmodule

// File: tb/tb_padattr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_padattr_sequencer
// Scoreboard bench: stimulus pushes expected (pad, value, cycle) applies and
// expected error pulses; a monitor watches the attribute buses and err_o on
// every falling edge and pops/compares whenever something changes.
// -----------------------------------------------------------------------------
module tb_padattr_sequencer;
    import padattr_pkg::*;

    localparam int NMio = 16;
    localparam int NDio = 4;
    localparam int Dw   = 8;
    localparam int Stg  = 4;
    localparam int IW   = 5;
    localparam int NP   = NMio + NDio;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [IW-1:0]      req_idx_i;
    logic [Dw-1:0]      req_attr_i;
    logic               freeze_i;
    logic               busy_o;
    logic               err_o;
    logic [NMio*Dw-1:0] mio_attr_o;
    logic [NDio*Dw-1:0] dio_attr_o;

    padattr_sequencer #(
        .NMioPads      (NMio),
        .NDioPads      (NDio),
        .AttrDw        (Dw),
        .StaggerCycles (Stg),
        .IdxW          (IW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_idx_i   (req_idx_i),
        .req_attr_i  (req_attr_i),
        .freeze_i    (freeze_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .mio_attr_o  (mio_attr_o),
        .dio_attr_o  (dio_attr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         pad;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t             sb_q[$];
    int               err_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    bit               mon_en   = 1'b0;
    logic [NP*Dw-1:0] model    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_all(input string name);
        n_checks++;
        if ({dio_attr_o, mio_attr_o} === model) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, {dio_attr_o, mio_attr_o}, model);
    endtask

    task automatic expect_apply(input int p, input logic [7:0] v, input int c);
        exp_t e;
        e.pad = p;
        e.val = v;
        e.cyc = c;
        sb_q.push_back(e);
        model[p*Dw +: Dw] = v;
    endtask

    // Returns at the falling edge where cyc has reached target.
    task automatic at_cyc(input int target);
        while (1) begin
            @(negedge clk);
            if (cyc >= target) break;
        end
    endtask

    task automatic step_to_pos();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; n is the cycle count when driven,
    // the write is accepted on the next rising edge.
    task automatic write(input int idx, input logic [7:0] attr, output int n);
        n = cyc;
        check("ready_at_write", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_idx_i   = IW'(idx);
        req_attr_i  = attr;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy_o !== 1'b0 || sb_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k < 200) n_pass++;
        else $display("FAIL %s: still busy after %0d cycles, expected idle", name, k);
    endtask

    // Monitor: every attribute change must match the head of the scoreboard.
    initial begin
        logic [NP*Dw-1:0] cur;
        logic [NP*Dw-1:0] prev;
        exp_t             e;
        int               ec;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {dio_attr_o, mio_attr_o};
            if (mon_en) begin
                for (int p = 0; p < NP; p++) begin
                    if (cur[p*Dw +: Dw] !== prev[p*Dw +: Dw]) begin
                        n_checks++;
                        if (sb_q.size() == 0) begin
                            $display("FAIL apply_unexpected: pad %0d became %h at cycle %0d, expected no change",
                                     p, cur[p*Dw +: Dw], cyc);
                        end else begin
                            e = sb_q.pop_front();
                            if (e.pad == p && e.val === cur[p*Dw +: Dw] && e.cyc == cyc) n_pass++;
                            else $display("FAIL apply: got pad %0d val %h cycle %0d, expected pad %0d val %h cycle %0d",
                                          p, cur[p*Dw +: Dw], cyc, e.pad, e.val, e.cyc);
                        end
                    end
                end
                if (err_o === 1'b1) begin
                    n_checks++;
                    if (err_q.size() == 0) begin
                        $display("FAIL err_unexpected: err_o high at cycle %0d, expected low", cyc);
                    end else begin
                        ec = err_q.pop_front();
                        if (ec == cyc) n_pass++;
                        else $display("FAIL err_pulse: got cycle %0d, expected cycle %0d", cyc, ec);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2, f, r;
        pad_loc_t loc;

        rst_i = 1'b1; req_valid_i = 1'b0; req_idx_i = '0; req_attr_i = '0; freeze_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_err",   err_o, 0);
        check("rst_mio",   mio_attr_o, 0);
        check("rst_dio",   dio_attr_o, 0);
        step_to_pos();
        rst_i = 1'b0;
        n = cyc;
        at_cyc(n);
        check("ready_first_cycle", req_ready_o, 0);
        at_cyc(n + 1);
        check("ready_second_cycle", req_ready_o, 1);
        step_to_pos();
        mon_en = 1'b1;

        // Single write: 3-cycle latency, busy drops StaggerCycles later
        write(3, 8'hA5, n);
        expect_apply(3, 8'hA5, n + 3);
        at_cyc(n + 2);
        check("t1_not_yet", mio_attr_o[31:24], 8'h00);
        at_cyc(n + 3);
        check("t1_mio3", mio_attr_o[31:24], 8'hA5);
        at_cyc(n + 2 + Stg);
        check("t1_busy_hold", busy_o, 1);
        at_cyc(n + 3 + Stg);
        check("t1_busy_drop", busy_o, 0);
        wait_idle("t1_idle");

        // Three writes gathered under freeze, then priority order 2, 7, 18
        step_to_pos();
        freeze_i = 1'b1;
        write(7,  8'h11, n);
        write(2,  8'h22, n1);
        write(18, 8'h33, n2);
        freeze_i = 1'b0;
        f = cyc;
        expect_apply(2,  8'h22, f + 2);
        expect_apply(7,  8'h11, f + 2 + (Stg + 1));
        expect_apply(18, 8'h33, f + 2 + 2 * (Stg + 1));
        loc = pad_split(18, NMio);
        at_cyc(f + 2 + 2 * (Stg + 1));
        check("t2_dio2", dio_attr_o[loc.local_idx*Dw +: Dw], 8'h33);
        wait_idle("t2_idle");

        // Freeze holds a pending write until released
        step_to_pos();
        freeze_i = 1'b1;
        write(0, 8'h0F, n);
        at_cyc(n + 6);
        check("t3_frozen_mio0", mio_attr_o[7:0], 8'h00);
        check("t3_frozen_busy", busy_o, 1);
        step_to_pos();
        freeze_i = 1'b0;
        f = cyc;
        expect_apply(0, 8'h0F, f + 2);
        at_cyc(f + 2);
        check("t3_mio0", mio_attr_o[7:0], 8'h0F);
        wait_idle("t3_idle");

        // Rewrite of pad 5 in its own APPLY cycle
        step_to_pos();
        write(5, 8'h01, n);
        expect_apply(5, 8'h01, n + 3);
        expect_apply(5, 8'h02, n + 3 + (Stg + 1));
        step_to_pos();
        write(5, 8'h02, n1);
        at_cyc(n + 3);
        check("t4_first", mio_attr_o[47:40], 8'h01);
        at_cyc(n + 3 + (Stg + 1));
        check("t4_second", mio_attr_o[47:40], 8'h02);
        wait_idle("t4_idle");

        // Out-of-range index: err pulse, nothing pending, attrs unchanged
        step_to_pos();
        write(25, 8'h5A, n);
        err_q.push_back(n + 1);
        at_cyc(n + 2);
        check("t5_busy", busy_o, 0);
        check("t5_err_low", err_o, 0);
        check_all("t5_attrs");

        // Reset during WAIT discards everything
        step_to_pos();
        write(1, 8'h44, n);
        write(4, 8'h55, n1);
        write(6, 8'h66, n2);
        expect_apply(1, 8'h44, n + 3);
        at_cyc(n + 3);
        #1;
        mon_en = 1'b0;
        rst_i  = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        r = cyc;
        model = '0;
        at_cyc(r);
        check("t6_mio", mio_attr_o, 0);
        check("t6_dio", dio_attr_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_ready", req_ready_o, 0);
        step_to_pos();
        mon_en = 1'b1;
        at_cyc(r + 25);
        check("t6_busy_after", busy_o, 0);
        check_all("t6_attrs_after");

        check("sb_empty",  sb_q.size(), 0);
        check("err_empty", err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
